// File: rtl/uart_tx_phy_if.sv
// Bank-side TX FIFO port: push strobe/data toward the PHY, FIFO status back to the bank.
interface uart_tx_phy_if;
    logic       tx_fifo_wr_en;
    logic [7:0] tx_fifo_wr_data;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic       tx_fifo_less_than_watermark;

    modport master (
        output tx_fifo_wr_en, tx_fifo_wr_data,
        input  tx_fifo_full, tx_fifo_empty, tx_fifo_less_than_watermark
    );
    modport slave (
        input  tx_fifo_wr_en, tx_fifo_wr_data,
        output tx_fifo_full, tx_fifo_empty, tx_fifo_less_than_watermark
    );
endinterface

// File: rtl/uart_tx_phy.sv
// UART transmit PHY: byte FIFO fed by the register bank, serialized as 8N1/8N2 frames on txd.
module uart_tx_phy #(
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          txen,
    input  logic          nstop,
    input  logic [15:0]   div,
    input  logic [CW-1:0] txcnt,
    uart_tx_phy_if.slave  bank,
    output logic          txd,
    output logic          tx_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   count;

    state_t        state;
    logic [7:0]    shift;
    logic [15:0]   baud;
    logic [15:0]   div_l;
    logic          nstop_l;
    logic          stop2;
    logic [2:0]    bit_idx;

    logic push, pop, last_stop;

    assign bank.tx_fifo_full                = (count == (CW+1)'(FIFO_DEPTH));
    assign bank.tx_fifo_empty               = (count == '0);
    assign bank.tx_fifo_less_than_watermark = (count < {1'b0, txcnt});

    assign push      = bank.tx_fifo_wr_en && !bank.tx_fifo_full;
    assign last_stop = (state == STOP) && (baud == '0) && (!nstop_l || stop2);
    // A pop happens from IDLE or on the final stop clock so frames can run back to back.
    assign pop       = txen && !bank.tx_fifo_empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bank.tx_fifo_wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // txd is registered from the current state, so the line lags the FSM by one clock uniformly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            shift   <= '0;
            baud    <= '0;
            div_l   <= '0;
            nstop_l <= 1'b0;
            stop2   <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        div_l   <= div;
                        nstop_l <= nstop;
                        baud    <= div;
                        state   <= START;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (baud == '0) begin
                        baud    <= div_l;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    txd <= shift[0];
                    if (baud == '0) begin
                        baud  <= div_l;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            stop2 <= 1'b0;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (baud != '0) begin
                        baud <= baud - 1'b1;
                    end else if (nstop_l && !stop2) begin
                        stop2 <= 1'b1;
                        baud  <= div_l;
                    end else if (pop) begin
                        shift   <= mem[rd_ptr];
                        div_l   <= div;
                        nstop_l <= nstop;
                        baud    <= div;
                        state   <= START;
                    end else begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_phy.sv
// Directed bench for uart_tx_phy: flag vector table plus hand-written frame timing sequences.
module tb_uart_tx_phy;

    localparam int FIFO_DEPTH = 8;
    localparam int CW         = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          txen;
    logic          nstop;
    logic [15:0]   div;
    logic [CW-1:0] txcnt;
    logic          txd;
    logic          tx_busy;

    uart_tx_phy_if bus ();

    uart_tx_phy #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .txen    (txen),
        .nstop   (nstop),
        .div     (div),
        .txcnt   (txcnt),
        .bank    (bus.slave),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clock = ~clock;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_wm;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.tx_fifo_wr_en   = 1'b0;
        bus.tx_fifo_wr_data = '0;
        txen    = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Called at a negedge; the push lands on the following posedge.
    task automatic push(input logic [7:0] d);
        bus.tx_fifo_wr_en   = 1'b1;
        bus.tx_fifo_wr_data = d;
        @(negedge clock);
        bus.tx_fifo_wr_en   = 1'b0;
    endtask

    task automatic wait_low(input string nm, output bit ok);
        int n = 0;
        while (txd !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        ok = (txd === 1'b0);
        if (!ok) chk(nm, 32'(txd), 0);
    endtask

    // Samples one frame starting at the negedge where the start bit is first seen.
    task automatic rx_frame(input int bitlen, input int nbits, output logic [7:0] b, output bit ok);
        logic smp [0:127];
        bit   fnd;
        b  = '0;
        wait_low("rx_start_timeout", fnd);
        ok = fnd;
        if (!fnd) return;
        for (int i = 0; i < nbits * bitlen; i++) begin
            smp[i] = txd;
            @(negedge clock);
        end
        for (int k = 0; k < nbits; k++) begin
            for (int j = 1; j < bitlen; j++)
                if (smp[k*bitlen+j] !== smp[k*bitlen]) ok = 0;
            if (k == 0 && smp[0] !== 1'b0) ok = 0;
            if (k >= 9 && smp[k*bitlen] !== 1'b1) ok = 0;
            if (k >= 1 && k <= 8) b[k-1] = smp[k*bitlen];
        end
    endtask

    task automatic quiet(input int n, input string nm);
        bit seen = 0;
        repeat (n) begin
            @(negedge clock);
            if (txd !== 1'b1) seen = 1;
        end
        chk(nm, 32'(seen), 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        logic [7:0] a5;
        logic [7:0] pair [2];
        logic       stream [0:21];
        int         idx;

        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        for (int k = 1; k <= 9; k++)
            vecs[k] = '{1'b1, 8'(k-1), (k >= 8), 1'b0, (k < 2)};

        nstop = 1'b0;
        div   = 16'd3;
        txcnt = '0;

        // 0xA5 at div=3, 8N1: exact per-clock line check
        do_reset();
        chk("rst_txd", 32'(txd), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_empty", 32'(bus.tx_fifo_empty), 1);
        chk("rst_full", 32'(bus.tx_fifo_full), 0);
        chk("rst_wm_txcnt0", 32'(bus.tx_fifo_less_than_watermark), 0);
        txen = 1'b1;
        a5   = 8'hA5;
        push(a5);
        chk("a5_txd_after_push", 32'(txd), 1);
        chk("a5_nonempty", 32'(bus.tx_fifo_empty), 0);
        @(negedge clock);
        chk("a5_busy_after_pop", 32'(tx_busy), 1);
        chk("a5_txd_high_after_pop", 32'(txd), 1);
        chk("a5_empty_after_pop", 32'(bus.tx_fifo_empty), 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            idx = i / 4;
            chk($sformatf("a5_bit%0d_clk%0d", idx, i % 4), 32'(txd),
                (idx == 0) ? 0 : (idx == 9) ? 1 : 32'(a5[idx-1]));
        end
        @(negedge clock);
        chk("a5_idle_txd", 32'(txd), 1);
        chk("a5_idle_busy", 32'(tx_busy), 0);

        // Flag vectors: txcnt=2, txen=0, nine pushes into a depth-8 FIFO
        do_reset();
        txcnt = 3'd2;
        for (int i = 0; i < 10; i++) begin
            bus.tx_fifo_wr_en   = vecs[i].wr_en;
            bus.tx_fifo_wr_data = vecs[i].data;
            @(negedge clock);
            chk($sformatf("vec%0d_full", i), 32'(bus.tx_fifo_full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_empty", i), 32'(bus.tx_fifo_empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_wm", i), 32'(bus.tx_fifo_less_than_watermark), 32'(vecs[i].exp_wm));
        end
        bus.tx_fifo_wr_en = 1'b0;
        chk("fill_idle_no_tx", 32'(tx_busy), 0);
        div  = 16'd1;
        txen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_frame(2, 10, b, ok);
            chk($sformatf("drain%0d_ok", i), 32'(ok), 1);
            chk($sformatf("drain%0d_byte", i), 32'(b), 32'(i));
        end
        chk("drain_empty", 32'(bus.tx_fifo_empty), 1);
        quiet(40, "drain_no_ninth_frame");

        // Watermark rises again when a pop drops count from 2 to 1
        do_reset();
        txcnt = 3'd2;
        push(8'h11);
        push(8'h22);
        chk("wm_count2", 32'(bus.tx_fifo_less_than_watermark), 0);
        txen = 1'b1;
        @(negedge clock);
        txen = 1'b0;
        chk("wm_after_pop", 32'(bus.tx_fifo_less_than_watermark), 1);
        chk("wm_after_pop_empty", 32'(bus.tx_fifo_empty), 0);

        // div=0, 8N2: two contiguous 11-clock frames
        do_reset();
        div     = 16'd0;
        nstop   = 1'b1;
        pair[0] = 8'h3C;
        pair[1] = 8'hC3;
        push(pair[0]);
        push(pair[1]);
        for (int f = 0; f < 2; f++) begin
            stream[f*11] = 1'b0;
            for (int k = 0; k < 8; k++) stream[f*11+1+k] = pair[f][k];
            stream[f*11+9]  = 1'b1;
            stream[f*11+10] = 1'b1;
        end
        txen = 1'b1;
        wait_low("b2b_start_timeout", ok);
        if (ok) begin
            for (int i = 0; i < 22; i++) begin
                chk($sformatf("b2b_clk%0d", i), 32'(txd), 32'(stream[i]));
                @(negedge clock);
            end
            chk("b2b_idle_after", 32'(txd), 1);
            chk("b2b_busy_after", 32'(tx_busy), 0);
        end
        nstop = 1'b0;

        // Full FIFO: push dropped while the same edge pops
        do_reset();
        div = 16'd1;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        chk("pp_full_before", 32'(bus.tx_fifo_full), 1);
        bus.tx_fifo_wr_en   = 1'b1;
        bus.tx_fifo_wr_data = 8'hEE;
        txen = 1'b1;
        @(negedge clock);
        bus.tx_fifo_wr_en = 1'b0;
        chk("pp_full_after", 32'(bus.tx_fifo_full), 0);
        chk("pp_busy", 32'(tx_busy), 1);
        for (int i = 0; i < 8; i++) begin
            rx_frame(2, 10, b, ok);
            chk($sformatf("pp%0d_ok", i), 32'(ok), 1);
            chk($sformatf("pp%0d_byte", i), 32'(b), 32'(8'h10 + 8'(i)));
        end
        chk("pp_empty_end", 32'(bus.tx_fifo_empty), 1);
        quiet(30, "pp_no_dropped_byte");

        // Async reset mid-frame flushes FIFO and idles the line immediately
        do_reset();
        div   = 16'd3;
        txcnt = '0;
        push(8'h55);
        push(8'h66);
        txen = 1'b1;
        wait_low("mid_start_timeout", ok);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 1);
        chk("mid_rst_busy", 32'(tx_busy), 0);
        chk("mid_rst_empty", 32'(bus.tx_fifo_empty), 1);
        chk("mid_rst_full", 32'(bus.tx_fifo_full), 0);
        chk("mid_rst_wm", 32'(bus.tx_fifo_less_than_watermark), 0);
        @(negedge clock);
        reset_n = 1'b1;
        quiet(30, "mid_rst_flushed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
